se_gap_div_ctrl: RTL and testbench

SE_GAP_DIV_CTRL -- requirements
Module: se_gap_div_ctrl

---
 rtl/se_gap_div_ctrl_pkg.sv | 18 +
 rtl/se_sat_acc.sv | 25 ++
 rtl/se_gap_div_ctrl.sv | 152 +++++++++++++++
 tb/tb_se_gap_div_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/se_gap_div_ctrl_pkg.sv
// rtl/se_gap_div_ctrl_pkg.sv - shared SE-block widths and GAP/divide controller state encoding
package se_gap_div_ctrl_pkg;

  localparam int SE_CH         = 16;
  localparam int SE_DATA_WIDTH = 16;
  localparam int SE_FBITS      = 9;
  localparam int SE_IN_WIDTH   = 26;
  localparam int SE_OUT_WIDTH  = 14;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACCUM    = 3'd1,
    ST_DIV_REQ  = 3'd2,
    ST_DIV_WAIT = 3'd3,
    ST_OUT      = 3'd4
  } gap_state_e;

endpackage

// File: rtl/se_sat_acc.sv
// rtl/se_sat_acc.sv - signed adder clamping to the W-bit signed range instead of wrapping
module se_sat_acc #(
  parameter int W = 26
) (
  input  logic signed [W-1:0] acc_i,
  input  logic signed [W-1:0] add_i,
  output logic signed [W-1:0] sum_o
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] full_sum;

  always_comb begin
    full_sum = {acc_i[W-1], acc_i} + {add_i[W-1], add_i};
    // The two top bits disagree only when the true sum left the W-bit range.
    if (full_sum[W] != full_sum[W-1]) begin
      sum_o = full_sum[W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_o = full_sum[W-1:0];
    end
  end

endmodule

// File: rtl/se_gap_div_ctrl.sv
// rtl/se_gap_div_ctrl.sv - per-channel global average pooling: accumulate a frame, divide each sum, stream means
module se_gap_div_ctrl
  import se_gap_div_ctrl_pkg::*;
#(
  parameter int CH         = SE_CH,
  parameter int DATA_WIDTH = SE_DATA_WIDTH,
  parameter int FBITS      = SE_FBITS,
  parameter int IN_WIDTH   = SE_IN_WIDTH,
  parameter int OUT_WIDTH  = SE_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic [15:0]                 num_pixels,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                        div_start,
  output logic [IN_WIDTH-1:0]         div_a,
  output logic [IN_WIDTH-1:0]         div_b,
  input  logic                        div_busy,
  input  logic                        div_done,
  input  logic [OUT_WIDTH-1:0]        div_val,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic [$clog2(CH)-1:0]       out_ch,
  output logic                        out_last,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int CHW = $clog2(CH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

  gap_state_e                  state_q, state_d;
  logic [CHW-1:0]              ch_cnt_q, ch_cnt_d;
  logic [CHW-1:0]              idx_q, idx_d;
  logic [15:0]                 pix_cnt_q, pix_cnt_d;
  logic [15:0]                 npix_q, npix_d;
  logic signed [IN_WIDTH-1:0]  acc_q [CH];
  logic signed [IN_WIDTH-1:0]  acc_d [CH];
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                        frame_done_q, frame_done_d;
  logic signed [IN_WIDTH-1:0]  beat_ext;
  logic signed [IN_WIDTH-1:0]  acc_sum;

  assign beat_ext = {{(IN_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  se_sat_acc #(.W(IN_WIDTH)) u_sat_acc (
    .acc_i (acc_q[ch_cnt_q]),
    .add_i (beat_ext),
    .sum_o (acc_sum)
  );

  always_comb begin
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    idx_d        = idx_q;
    pix_cnt_d    = pix_cnt_q;
    npix_d       = npix_q;
    acc_d        = acc_q;
    out_data_d   = out_data_q;
    frame_done_d = 1'b0;
    div_start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start && (num_pixels != 16'd0)) begin
          npix_d    = num_pixels;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          idx_d     = '0;
          for (int i = 0; i < CH; i++) acc_d[i] = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d[ch_cnt_q] = acc_sum;
          if (ch_cnt_q == LAST_CH) begin
            ch_cnt_d  = '0;
            pix_cnt_d = pix_cnt_q + 16'd1;
            if (pix_cnt_q == npix_q - 16'd1) begin
              idx_d   = '0;
              state_d = ST_DIV_REQ;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CHW'(1);
          end
        end
      end
      ST_DIV_REQ: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          out_data_d = div_val;
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (idx_q == LAST_CH) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            idx_d   = idx_q + CHW'(1);
            state_d = ST_DIV_REQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ch_cnt_q     <= '0;
      idx_q        <= '0;
      pix_cnt_q    <= '0;
      npix_q       <= '0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      idx_q        <= idx_d;
      pix_cnt_q    <= pix_cnt_d;
      npix_q       <= npix_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Accumulators are frozen outside ACCUM, so the operands hold for the whole divide.
  assign div_a      = acc_q[idx_q];
  assign div_b      = IN_WIDTH'({npix_q, {FBITS{1'b0}}});
  assign in_ready   = (state_q == ST_ACCUM);
  assign out_valid  = (state_q == ST_OUT);
  assign out_data   = out_data_q;
  assign out_ch     = idx_q;
  assign out_last   = (state_q == ST_OUT) && (idx_q == LAST_CH);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_se_gap_div_ctrl.sv
// tb/tb_se_gap_div_ctrl.sv - self-checking bench for se_gap_div_ctrl with a behavioural divider
module tb_se_gap_div_ctrl;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int FB = 9;
  localparam int IW = 26;
  localparam int OW = 14;
  localparam longint ACC_MAX = 33554431;
  localparam longint ACC_MIN = -33554432;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 frame_start = 1'b0;
  logic [15:0]          num_pixels = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_data = '0;
  logic                 div_start;
  logic [IW-1:0]        div_a, div_b;
  logic                 div_busy = 1'b0;
  logic                 div_done = 1'b0;
  logic [OW-1:0]        div_val = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_data;
  logic [0:0]           out_ch;
  logic                 out_last;
  logic                 busy;
  logic                 frame_done;

  int ntests = 0;
  int nfail  = 0;

  logic [IW-1:0] la = '0, lb = '0;
  int dcnt = 0;
  int n_starts = 0;
  int force_lat = 0;

  se_gap_div_ctrl #(.CH(CH), .DATA_WIDTH(DW), .FBITS(FB), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .num_pixels(num_pixels),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_busy(div_busy), .div_done(div_done), .div_val(div_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] div_model(input logic [IW-1:0] a, input logic [IW-1:0] b);
    longint sa = longint'($signed(a));
    longint ub = longint'({38'd0, b});
    longint q  = (sa * 512) / ub;
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return OW'(q);
  endfunction

  // Divider stand-in: random latency, busy while working, one-cycle done pulse.
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_done <= 1'b1;
        div_busy <= 1'b0;
        div_val  <= div_model(la, lb);
      end
    end else if (div_start) begin
      la       <= div_a;
      lb       <= div_b;
      dcnt     <= (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      div_busy <= 1'b1;
      n_starts <= n_starts + 1;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat_add(input longint s, input longint d);
    longint r = s + d;
    if (r > ACC_MAX) r = ACC_MAX;
    if (r < ACC_MIN) r = ACC_MIN;
    return r;
  endfunction

  function automatic longint ref_mean(input longint s, input int np);
    longint q = s / longint'(np);
    if (q > 8191) q = 8191;
    if (q < -8192) q = -8192;
    return q;
  endfunction

  function automatic int gen_data(input int mode, input int p, input int c);
    int tbl[4] = '{512, 1024, -512, 1024};
    case (mode)
      1:       return (c == 0) ? tbl[p] : -256;
      2:       return 32767;
      3:       return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic send_beat(input int d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = DW'(d);
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int np, input int mode, input int hold_ch);
    longint sum[CH];
    int t;
    int s0;
    logic signed [OW-1:0] d0;
    for (int c = 0; c < CH; c++) sum[c] = 0;
    frame_start = 1'b1;
    num_pixels  = 16'(np);
    @(negedge clk);
    frame_start = 1'b0;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < CH; c++) begin
        int d = gen_data(mode, p, c);
        sum[c] = sat_add(sum[c], longint'(d));
        if (mode == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(d);
        if (mode == 1 && p == 1 && c == 0) begin
          frame_start = 1'b1;
          num_pixels  = 16'd2;
          @(negedge clk);
          frame_start = 1'b0;
          num_pixels  = 16'(np);
          chk("ignored_fs_busy", busy, 1);
          chk("ignored_fs_in_ready", in_ready, 1);
        end
      end
    end
    for (int c = 0; c < CH; c++) begin
      t = 0;
      while (out_valid !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("out_valid", out_valid, 1);
      chk("out_ch", out_ch, c);
      chk("out_last", out_last, (c == CH - 1) ? 1 : 0);
      chk("out_data", out_data, ref_mean(sum[c], np));
      chk("div_a", $signed(la), sum[c]);
      chk("div_b", lb, longint'(np) * 512);
      if (c == hold_ch) begin
        s0 = n_starts;
        d0 = out_data;
        repeat (10) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, d0);
        end
        chk("hold_no_start", n_starts, s0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (c == CH - 1) begin
        chk("frame_done_pulse", frame_done, 1);
        chk("busy_after_frame", busy, 0);
        @(negedge clk);
        chk("frame_done_clear", frame_done, 0);
      end else begin
        chk("frame_done_early", frame_done, 0);
      end
    end
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);

    frame_start = 1'b1;
    num_pixels  = 16'd0;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk("np0_busy", busy, 0);
    chk("np0_in_ready", in_ready, 0);

    run_frame(4, 1, 0);
    repeat (4) run_frame(int'($urandom_range(1, 8)), 0, -1);
    run_frame(4096, 2, -1);
    run_frame(4096, 3, -1);

    force_lat = 12;
    frame_start = 1'b1;
    num_pixels  = 16'd2;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 2 * CH; i++) send_beat(1000 + i);
    t = 0;
    while (div_busy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_divide_busy", div_busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_div_start", div_start, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_ch", out_ch, 0);
    chk("arst_out_last", out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (div_done !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("late_done_seen", div_done, 1);
    @(negedge clk);
    chk("late_done_busy", busy, 0);
    chk("late_done_out_valid", out_valid, 0);
    force_lat = 0;
    run_frame(3, 0, -1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
